// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator: opcodes, FSM states, flag bit positions.
package calc_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int FLG_OVF = 0;
  localparam int FLG_DBZ = 1;
endpackage

// File: rtl/calc_muldiv_iter.sv
// One iteration of shift-add multiply (BITS_PER_CYCLE bits) or restoring divide (1 bit).
module calc_muldiv_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int BPC = BITS_PER_CYCLE;

  // Multiply: hi = partial product, lo = multiplier shifting out / product low bits shifting in.
  logic [WIDTH+BPC-1:0] w_pp, w_sum;
  assign w_pp  = {{BPC{1'b0}}, i_opnd} * {{WIDTH{1'b0}}, i_lo[BPC-1:0]};
  assign w_sum = {{BPC{1'b0}}, i_hi} + w_pp;

  // Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  logic [WIDTH:0] w_rs, w_df;
  logic           w_ge;
  assign w_rs = {i_hi, i_lo[WIDTH-1]};
  assign w_df = w_rs - {1'b0, i_opnd};
  assign w_ge = ~w_df[WIDTH];

  always_comb begin
    o_hi = w_sum[WIDTH+BPC-1:BPC];
    o_lo = {w_sum[BPC-1:0], i_lo[WIDTH-1:BPC]};
    if (i_div) begin
      o_hi = w_ge ? w_df[WIDTH-1:0] : w_rs[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_ge};
    end
  end
endmodule

// File: rtl/calc_seq_unit.sv
// Sequential ADD/SUB/MUL/DIV unit with valid/ready request and result handshakes.
module calc_seq_unit
  import calc_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           r_state, w_nxt;
  op_e              r_op, w_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_result, r_result_hi;
  logic [WIDTH-1:0] w_nhi, w_nlo;
  logic [1:0]       r_flags;
  logic [CW-1:0]    r_cnt, w_iters;
  logic             w_last, w_div, w_bz;
  logic [WIDTH:0]   w_add, w_sub;

  assign w_op    = op_e'(op);
  assign w_div   = (r_op == OP_DIV);
  assign w_bz    = (b == '0);
  assign w_iters = w_div ? CW'(WIDTH) : CW'(WIDTH / BITS_PER_CYCLE);
  assign w_last  = (r_cnt == w_iters - CW'(1));
  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} - {1'b0, b};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flags     = r_flags;

  calc_muldiv_iter #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_iter (
    .i_div  (w_div),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .i_opnd (w_div ? r_b : r_a),
    .o_hi   (w_nhi),
    .o_lo   (w_nlo)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (in_valid) begin
        if (w_op == OP_MUL || (w_op == OP_DIV && !w_bz)) w_nxt = EXEC;
        else                                            w_nxt = DONE;
      end
      EXEC:    if (w_last)    w_nxt = DONE;
      DONE:    if (out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a   <= a;
          r_b   <= b;
          r_op  <= w_op;
          r_cnt <= '0;
          r_hi  <= '0;
          r_lo  <= (w_op == OP_MUL) ? b : a;
          case (w_op)
            OP_ADD: begin
              r_result          <= w_add[WIDTH-1:0];
              r_result_hi       <= {{(WIDTH-1){1'b0}}, w_add[WIDTH]};
              r_flags           <= '0;
              r_flags[FLG_OVF]  <= w_add[WIDTH];
            end
            OP_SUB: begin
              r_result          <= w_sub[WIDTH-1:0];
              r_result_hi       <= {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
              r_flags           <= '0;
              r_flags[FLG_OVF]  <= w_sub[WIDTH];
            end
            OP_DIV: if (w_bz) begin
              r_result          <= '1;
              r_result_hi       <= a;
              r_flags           <= '0;
              r_flags[FLG_DBZ]  <= 1'b1;
            end
            default: ;
          endcase
        end
        EXEC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt            <= '0;
            r_result         <= w_nlo;
            r_result_hi      <= w_nhi;
            r_flags          <= '0;
            r_flags[FLG_OVF] <= !w_div && (w_nhi != '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
